// File: rtl/issue_stage_pkg.sv
// Shared entry layout, uop class bits and helpers for the issue stage.
// Optional performance counters are enabled with ISSUE_STAGE_PERF_EN.
package issue_stage_pkg;

    localparam int WIDTH_UOP = 8;
    localparam int REG_W     = 5;
    localparam int XLEN      = 32;
    localparam int EXP_W     = 7;

    // Bit positions of the one-hot instruction class inside uop
    typedef enum int {
        ITYPE_IDX_ALU = 0,
        ITYPE_IDX_MEM = 1,
        ITYPE_IDX_BR  = 2,
        ITYPE_IDX_CSR = 3
    } itype_idx_e;

    // Packed decoded uop; first field is the MSB of the flat entry
    typedef struct packed {
        logic [WIDTH_UOP-1:0] uop;
        logic [REG_W-1:0]     rd;
        logic [REG_W-1:0]     rj;
        logic [REG_W-1:0]     rk;
        logic [XLEN-1:0]      pc;
        logic [XLEN-1:0]      pc_next;
        logic [EXP_W-1:0]     exp;
        logic [XLEN-1:0]      imm;
        logic [XLEN-1:0]      badv;
        logic                 unknown;
    } issue_ent_t;

    localparam int ISSUE_ENT_W = $bits(issue_ent_t);

    function automatic logic [1:0] popcnt2(input logic [1:0] v);
        return {1'b0, v[0]} + {1'b0, v[1]};
    endfunction

endpackage

// File: rtl/issue_stage_fifo.sv
// Dual-push, dual-peek, variable-pop circular buffer for the issue stage.
// Pointers carry a wrap bit so count spans 0..DEPTH without ambiguity.
module issue_stage_fifo
    import issue_stage_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic [1:0]             push_n,
    input  logic [1:0]             pop_n,
    input  issue_ent_t             wdata0,
    input  issue_ent_t             wdata1,
    output issue_ent_t             head0,
    output issue_ent_t             head1,
    output logic [$clog2(DEPTH):0] count
);

    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0] rd_q;
    logic [PW-1:0] rd_d;
    logic [PW-1:0] wr_q;
    logic [PW-1:0] wr_d;

    logic [AW-1:0] rd_idx;
    logic [AW-1:0] rd_idx1;
    logic [AW-1:0] wr_idx;
    logic [AW-1:0] wr_idx1;

    issue_ent_t mem_q [DEPTH];

    assign rd_idx  = rd_q[AW-1:0];
    assign rd_idx1 = rd_idx + AW'(1);
    assign wr_idx  = wr_q[AW-1:0];
    assign wr_idx1 = wr_idx + AW'(1);

    assign count = wr_q - rd_q;
    assign head0 = mem_q[rd_idx];
    assign head1 = mem_q[rd_idx1];

    // Advance pointers by push/pop amounts; flush overrides both
    always_comb begin
        rd_d = rd_q + PW'(pop_n);
        wr_d = wr_q + PW'(push_n);
        if (flush) begin
            rd_d = '0;
            wr_d = '0;
        end
    end

    // Pointer registers; reset empties the queue
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_q <= '0;
            wr_q <= '0;
        end else begin
            rd_q <= rd_d;
            wr_q <= wr_d;
        end
    end

    // Entry storage; slot0 lands at the tail, slot1 right after it
    always_ff @(posedge clk) begin
        if (push_n != 2'd0) begin
            mem_q[wr_idx] <= wdata0;
        end
        if (push_n == 2'd2) begin
            mem_q[wr_idx1] <= wdata1;
        end
    end

endmodule

// File: rtl/issue_stage.sv
// Dual-issue buffer between decode and register_file: pairing, pop, unpack.
// Define ISSUE_STAGE_PERF_EN to add saturating issue-rate counters.
module issue_stage
    import issue_stage_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                   clk,
    input  logic                   rstn,
    input  logic                   flush,
    input  logic                   stall,
    input  logic                   stall_by_conflict,
    input  logic [1:0]             in_valid,
    output logic                   in_ready,
    input  logic [ISSUE_ENT_W-1:0] in0_entry,
    input  logic [ISSUE_ENT_W-1:0] in1_entry,
    output logic                   eu0_en_out,
    output logic [WIDTH_UOP-1:0]   eu0_uop_out,
    output logic [4:0]             eu0_rd_out,
    output logic [4:0]             eu0_rj_out,
    output logic [4:0]             eu0_rk_out,
    output logic [31:0]            eu0_pc_out,
    output logic [31:0]            eu0_pc_next_out,
    output logic [6:0]             eu0_exp_out,
    output logic [31:0]            eu0_imm_out,
    output logic [31:0]            eu0_badv_out,
    output logic                   eu0_unknown_out,
    output logic                   eu1_en_out,
    output logic [WIDTH_UOP-1:0]   eu1_uop_out,
    output logic [4:0]             eu1_rd_out,
    output logic [4:0]             eu1_rj_out,
    output logic [4:0]             eu1_rk_out,
    output logic [31:0]            eu1_pc_out,
    output logic [31:0]            eu1_pc_next_out,
    output logic [6:0]             eu1_exp_out,
    output logic [31:0]            eu1_imm_out,
    output logic [31:0]            eu1_badv_out,
    output logic                   eu1_unknown_out
`ifdef ISSUE_STAGE_PERF_EN
    ,
    output logic [31:0]            perf_dual_cnt,
    output logic [31:0]            perf_single_cnt,
    output logic [31:0]            perf_empty_cnt
`endif
);

    localparam int CW = $clog2(DEPTH) + 1;

    issue_ent_t    w0;
    issue_ent_t    w1;
    issue_ent_t    h0;
    issue_ent_t    h1;
    issue_ent_t    e0;
    issue_ent_t    e1;
    logic [CW-1:0] count;
    logic [1:0]    push_n;
    logic [1:0]    pop_n;
    logic          en0;
    logic          en1;
    logic          raw_hazard;
    logic          clean;
    logic          pair_ok;

    assign w0 = in0_entry;
    assign w1 = in1_entry;

    // Room for a full pair is judged from the registered count alone
    assign in_ready = (count <= CW'(DEPTH - 2));
    assign push_n   = (in_ready && !flush) ? popcnt2(in_valid) : 2'd0;

    // The younger uop may not read what the older one writes (r0 excepted)
    assign raw_hazard = (h0.rd != '0) &&
                        ((h0.rd == h1.rj) || (h0.rd == h1.rk));
    assign clean      = (h0.exp == '0) && (h1.exp == '0) &&
                        !h0.unknown && !h1.unknown;
    assign pair_ok    = h1.uop[ITYPE_IDX_ALU] && !raw_hazard && clean;

    assign en0 = (count != '0);
    assign en1 = (count >= CW'(2)) && pair_ok;

    // Packets are re-presented while the backend holds them
    assign pop_n = (stall || stall_by_conflict) ? 2'd0
                 : ({1'b0, en0} + {1'b0, en1});

    issue_stage_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .flush  (flush),
        .push_n (push_n),
        .pop_n  (pop_n),
        .wdata0 (w0),
        .wdata1 (w1),
        .head0  (h0),
        .head1  (h1),
        .count  (count)
    );

    // Idle slots drive zeros rather than stale storage
    assign e0 = en0 ? h0 : '0;
    assign e1 = en1 ? h1 : '0;

    assign eu0_en_out      = en0;
    assign eu0_uop_out     = e0.uop;
    assign eu0_rd_out      = e0.rd;
    assign eu0_rj_out      = e0.rj;
    assign eu0_rk_out      = e0.rk;
    assign eu0_pc_out      = e0.pc;
    assign eu0_pc_next_out = e0.pc_next;
    assign eu0_exp_out     = e0.exp;
    assign eu0_imm_out     = e0.imm;
    assign eu0_badv_out    = e0.badv;
    assign eu0_unknown_out = e0.unknown;

    assign eu1_en_out      = en1;
    assign eu1_uop_out     = e1.uop;
    assign eu1_rd_out      = e1.rd;
    assign eu1_rj_out      = e1.rj;
    assign eu1_rk_out      = e1.rk;
    assign eu1_pc_out      = e1.pc;
    assign eu1_pc_next_out = e1.pc_next;
    assign eu1_exp_out     = e1.exp;
    assign eu1_imm_out     = e1.imm;
    assign eu1_badv_out    = e1.badv;
    assign eu1_unknown_out = e1.unknown;

`ifdef ISSUE_STAGE_PERF_EN
    logic [31:0] perf_dual_q;
    logic [31:0] perf_single_q;
    logic [31:0] perf_empty_q;

    // Saturating issue-rate counters; flush leaves them alone
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            perf_dual_q   <= '0;
            perf_single_q <= '0;
            perf_empty_q  <= '0;
        end else begin
            if (pop_n == 2'd2 && perf_dual_q != '1) begin
                perf_dual_q <= perf_dual_q + 32'd1;
            end
            if (pop_n == 2'd1 && perf_single_q != '1) begin
                perf_single_q <= perf_single_q + 32'd1;
            end
            if (count == '0 && !stall && perf_empty_q != '1) begin
                perf_empty_q <= perf_empty_q + 32'd1;
            end
        end
    end

    assign perf_dual_cnt   = perf_dual_q;
    assign perf_single_cnt = perf_single_q;
    assign perf_empty_cnt  = perf_empty_q;
`endif

endmodule

// File: tb/tb_issue_stage.sv
// Directed bench for issue_stage with a scoreboard queue and a monitor.
// Optional ISSUE_STAGE_PERF_EN ports are connected when the macro is set.
module tb_issue_stage;
    import issue_stage_pkg::*;

    localparam int DEPTH = 8;
    localparam logic [WIDTH_UOP-1:0] U_ALU = WIDTH_UOP'(1) << ITYPE_IDX_ALU;
    localparam logic [WIDTH_UOP-1:0] U_MEM = WIDTH_UOP'(1) << ITYPE_IDX_MEM;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic flush = 1'b0;
    logic stall = 1'b0;
    logic stall_by_conflict = 1'b0;
    logic [1:0] in_valid = 2'b00;
    logic in_ready;
    logic [ISSUE_ENT_W-1:0] in0_entry = '0;
    logic [ISSUE_ENT_W-1:0] in1_entry = '0;

    logic eu0_en_out, eu1_en_out;
    logic [WIDTH_UOP-1:0] eu0_uop_out, eu1_uop_out;
    logic [4:0] eu0_rd_out, eu0_rj_out, eu0_rk_out;
    logic [4:0] eu1_rd_out, eu1_rj_out, eu1_rk_out;
    logic [31:0] eu0_pc_out, eu0_pc_next_out, eu0_imm_out, eu0_badv_out;
    logic [31:0] eu1_pc_out, eu1_pc_next_out, eu1_imm_out, eu1_badv_out;
    logic [6:0] eu0_exp_out, eu1_exp_out;
    logic eu0_unknown_out, eu1_unknown_out;
`ifdef ISSUE_STAGE_PERF_EN
    logic [31:0] perf_dual_cnt, perf_single_cnt, perf_empty_cnt;
`endif

    typedef struct {
        logic        en1;
        logic [4:0]  rd0;
        logic [4:0]  rd1;
        logic [31:0] pc0;
    } exp_t;

    exp_t exp_q[$];
    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    issue_stage #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rstn(rstn), .flush(flush), .stall(stall),
        .stall_by_conflict(stall_by_conflict),
        .in_valid(in_valid), .in_ready(in_ready),
        .in0_entry(in0_entry), .in1_entry(in1_entry),
        .eu0_en_out(eu0_en_out), .eu0_uop_out(eu0_uop_out),
        .eu0_rd_out(eu0_rd_out), .eu0_rj_out(eu0_rj_out),
        .eu0_rk_out(eu0_rk_out), .eu0_pc_out(eu0_pc_out),
        .eu0_pc_next_out(eu0_pc_next_out), .eu0_exp_out(eu0_exp_out),
        .eu0_imm_out(eu0_imm_out), .eu0_badv_out(eu0_badv_out),
        .eu0_unknown_out(eu0_unknown_out),
        .eu1_en_out(eu1_en_out), .eu1_uop_out(eu1_uop_out),
        .eu1_rd_out(eu1_rd_out), .eu1_rj_out(eu1_rj_out),
        .eu1_rk_out(eu1_rk_out), .eu1_pc_out(eu1_pc_out),
        .eu1_pc_next_out(eu1_pc_next_out), .eu1_exp_out(eu1_exp_out),
        .eu1_imm_out(eu1_imm_out), .eu1_badv_out(eu1_badv_out),
        .eu1_unknown_out(eu1_unknown_out)
`ifdef ISSUE_STAGE_PERF_EN
        ,
        .perf_dual_cnt(perf_dual_cnt),
        .perf_single_cnt(perf_single_cnt),
        .perf_empty_cnt(perf_empty_cnt)
`endif
    );

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] want);
        n_chk++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got %0h, required %0h", nm, act, want);
        end
    endtask

    function automatic issue_ent_t mk(input logic [WIDTH_UOP-1:0] uop,
                                      input logic [4:0] rd,
                                      input logic [4:0] rj,
                                      input logic [4:0] rk,
                                      input logic [31:0] pc,
                                      input logic [6:0] ex,
                                      input logic unk);
        issue_ent_t e;
        e.uop = uop;
        e.rd = rd;
        e.rj = rj;
        e.rk = rk;
        e.pc = pc;
        e.pc_next = pc + 32'd4;
        e.exp = ex;
        e.imm = 32'h0;
        e.badv = 32'h0;
        e.unknown = unk;
        return e;
    endfunction

    task automatic exp_push(input logic en1, input logic [4:0] r0,
                            input logic [4:0] r1, input logic [31:0] pc0);
        exp_t e;
        e.en1 = en1;
        e.rd0 = r0;
        e.rd1 = r1;
        e.pc0 = pc0;
        exp_q.push_back(e);
    endtask

    task automatic push2(input issue_ent_t a, input issue_ent_t b);
        in0_entry = a;
        in1_entry = b;
        in_valid = 2'b11;
        @(posedge clk);
        #1;
        in_valid = 2'b00;
    endtask

    task automatic push1(input issue_ent_t a);
        in0_entry = a;
        in_valid = 2'b01;
        @(posedge clk);
        #1;
        in_valid = 2'b00;
    endtask

    task automatic drain();
        int n = 0;
        while (eu0_en_out && n < 40) begin
            @(posedge clk);
            #1;
            n++;
        end
        chk("drain_done", 32'(eu0_en_out), 32'd0);
        chk("sb_empty", 32'(exp_q.size()), 32'd0);
    endtask

    // Monitor: compare presented packets whenever the backend can take them
    always @(negedge clk) begin
        if (rstn && eu0_en_out && !stall) begin
            if (exp_q.size() == 0) begin
                n_chk++;
                n_fail++;
                $display("FAIL sb_unexpected: got eu0 rd=%0d, required none",
                         eu0_rd_out);
            end else begin
                chk("eu0_rd", 32'(eu0_rd_out), 32'(exp_q[0].rd0));
                chk("eu0_pc", eu0_pc_out, exp_q[0].pc0);
                chk("eu1_en", 32'(eu1_en_out), 32'(exp_q[0].en1));
                if (exp_q[0].en1) begin
                    chk("eu1_rd", 32'(eu1_rd_out), 32'(exp_q[0].rd1));
                end
                if (!stall_by_conflict) begin
                    void'(exp_q.pop_front());
                end
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish, required finish");
        $fatal(1, "timeout");
    end

    initial begin
        int m;
        int kk;
        // 1: reset state
        #12;
        chk("rst_en0", 32'(eu0_en_out), 32'd0);
        chk("rst_en1", 32'(eu1_en_out), 32'd0);
        chk("rst_ready", 32'(in_ready), 32'd1);
        chk("rst_rd0", 32'(eu0_rd_out), 32'd0);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        @(posedge clk);
        #1;
        chk("idle_en0", 32'(eu0_en_out), 32'd0);
        chk("idle_ready", 32'(in_ready), 32'd1);

        // 2: independent ALU pair dual-issues
        exp_push(1'b1, 5'd3, 5'd4, 32'h100);
        push2(mk(U_ALU, 5'd3, 5'd1, 5'd2, 32'h100, 7'h0, 1'b0),
              mk(U_ALU, 5'd4, 5'd5, 5'd6, 32'h104, 7'h0, 1'b0));
        chk("t2_en1", 32'(eu1_en_out), 32'd1);
        @(posedge clk);
        #1;
        chk("t2_after_en0", 32'(eu0_en_out), 32'd0);
        chk("t2_after_en1", 32'(eu1_en_out), 32'd0);
        drain();

        // 3: RAW through rj splits the pair
        exp_push(1'b0, 5'd5, 5'd0, 32'h110);
        exp_push(1'b0, 5'd6, 5'd0, 32'h114);
        push2(mk(U_ALU, 5'd5, 5'd1, 5'd2, 32'h110, 7'h0, 1'b0),
              mk(U_ALU, 5'd6, 5'd5, 5'd7, 32'h114, 7'h0, 1'b0));
        drain();

        // 3b: RAW through rk
        exp_push(1'b0, 5'd5, 5'd0, 32'h120);
        exp_push(1'b0, 5'd6, 5'd0, 32'h124);
        push2(mk(U_ALU, 5'd5, 5'd1, 5'd2, 32'h120, 7'h0, 1'b0),
              mk(U_ALU, 5'd6, 5'd1, 5'd5, 32'h124, 7'h0, 1'b0));
        drain();

        // 4: ALU + MEM single-issues
        exp_push(1'b0, 5'd9, 5'd0, 32'h300);
        exp_push(1'b0, 5'd8, 5'd0, 32'h304);
        push2(mk(U_ALU, 5'd9, 5'd1, 5'd2, 32'h300, 7'h0, 1'b0),
              mk(U_MEM, 5'd8, 5'd1, 5'd0, 32'h304, 7'h0, 1'b0));
        drain();

        // 4b: head with exception
        exp_push(1'b0, 5'd11, 5'd0, 32'h310);
        exp_push(1'b0, 5'd12, 5'd0, 32'h314);
        push2(mk(U_ALU, 5'd11, 5'd1, 5'd2, 32'h310, 7'h1, 1'b0),
              mk(U_ALU, 5'd12, 5'd1, 5'd2, 32'h314, 7'h0, 1'b0));
        drain();

        // 4c: head+1 unknown
        exp_push(1'b0, 5'd13, 5'd0, 32'h320);
        exp_push(1'b0, 5'd14, 5'd0, 32'h324);
        push2(mk(U_ALU, 5'd13, 5'd1, 5'd2, 32'h320, 7'h0, 1'b0),
              mk(U_ALU, 5'd14, 5'd1, 5'd2, 32'h324, 7'h0, 1'b1));
        drain();

        // 4d: head writes r0, head+1 reads r0 -> still pairs
        exp_push(1'b1, 5'd0, 5'd15, 32'h330);
        push2(mk(U_ALU, 5'd0, 5'd1, 5'd2, 32'h330, 7'h0, 1'b0),
              mk(U_ALU, 5'd15, 5'd0, 5'd0, 32'h334, 7'h0, 1'b0));
        drain();

        // 4e: equal rd pairs
        exp_push(1'b1, 5'd7, 5'd7, 32'h340);
        push2(mk(U_ALU, 5'd7, 5'd1, 5'd2, 32'h340, 7'h0, 1'b0),
              mk(U_ALU, 5'd7, 5'd3, 5'd4, 32'h344, 7'h0, 1'b0));
        drain();

        // mid-operation reset drops entries
        stall = 1'b1;
        push2(mk(U_ALU, 5'd1, 5'd2, 5'd3, 32'h380, 7'h0, 1'b0),
              mk(U_ALU, 5'd2, 5'd3, 5'd4, 32'h384, 7'h0, 1'b0));
        chk("mr_pre_en0", 32'(eu0_en_out), 32'd1);
        #2;
        rstn = 1'b0;
        #1;
        chk("mr_en0", 32'(eu0_en_out), 32'd0);
        chk("mr_en1", 32'(eu1_en_out), 32'd0);
        chk("mr_ready", 32'(in_ready), 32'd1);
        @(posedge clk);
        #1;
        rstn = 1'b1;
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("mr_post_en0", 32'(eu0_en_out), 32'd0);

        // 5a: fill under stall from odd count, then drain across wrap
        for (int k = 0; k < 3; k++) begin
            exp_push(1'b1, 5'(10 + 2 * k), 5'(11 + 2 * k), 32'(32'h200 + 8 * k));
        end
        exp_push(1'b0, 5'd16, 5'd0, 32'h218);
        stall = 1'b1;
        push1(mk(U_ALU, 5'd10, 5'd1, 5'd2, 32'h200, 7'h0, 1'b0));
        m = 1;
        kk = 1;
        for (int c = 0; c < 6; c++) begin
            chk("t5a_ready", 32'(in_ready), 32'(m <= DEPTH - 2));
            in0_entry = mk(U_ALU, 5'(10 + kk), 5'd1, 5'd2,
                           32'(32'h200 + 4 * kk), 7'h0, 1'b0);
            in1_entry = mk(U_ALU, 5'(11 + kk), 5'd1, 5'd2,
                           32'(32'h204 + 4 * kk), 7'h0, 1'b0);
            in_valid = 2'b11;
            @(posedge clk);
            #1;
            if (m <= DEPTH - 2) begin
                m = m + 2;
                kk = kk + 2;
            end
        end
        in_valid = 2'b00;
        stall = 1'b0;
        drain();

        // 5b: fill to exactly DEPTH, then drain
        for (int k = 0; k < 4; k++) begin
            exp_push(1'b1, 5'(20 + 2 * k), 5'(21 + 2 * k), 32'(32'h400 + 8 * k));
        end
        stall = 1'b1;
        m = 0;
        kk = 0;
        for (int c = 0; c < 6; c++) begin
            chk("t5b_ready", 32'(in_ready), 32'(m <= DEPTH - 2));
            in0_entry = mk(U_ALU, 5'(20 + kk), 5'd1, 5'd2,
                           32'(32'h400 + 4 * kk), 7'h0, 1'b0);
            in1_entry = mk(U_ALU, 5'(21 + kk), 5'd1, 5'd2,
                           32'(32'h404 + 4 * kk), 7'h0, 1'b0);
            in_valid = 2'b11;
            @(posedge clk);
            #1;
            if (m <= DEPTH - 2) begin
                m = m + 2;
                kk = kk + 2;
            end
        end
        in_valid = 2'b00;
        stall = 1'b0;
        drain();

        // 6: conflict bubble re-presents the same pair
        exp_push(1'b1, 5'd28, 5'd29, 32'h600);
        push2(mk(U_ALU, 5'd28, 5'd1, 5'd2, 32'h600, 7'h0, 1'b0),
              mk(U_ALU, 5'd29, 5'd1, 5'd2, 32'h604, 7'h0, 1'b0));
        stall_by_conflict = 1'b1;
        @(posedge clk);
        #1;
        stall_by_conflict = 1'b0;
        drain();

        // 6b: flush with 5 queued during stall; same-cycle push ignored
        stall = 1'b1;
        push1(mk(U_ALU, 5'd30, 5'd1, 5'd2, 32'h700, 7'h0, 1'b0));
        push2(mk(U_ALU, 5'd31, 5'd1, 5'd2, 32'h704, 7'h0, 1'b0),
              mk(U_ALU, 5'd1, 5'd1, 5'd2, 32'h708, 7'h0, 1'b0));
        push2(mk(U_ALU, 5'd2, 5'd1, 5'd2, 32'h70c, 7'h0, 1'b0),
              mk(U_ALU, 5'd3, 5'd1, 5'd2, 32'h710, 7'h0, 1'b0));
        chk("fl_pre_en0", 32'(eu0_en_out), 32'd1);
        flush = 1'b1;
        in_valid = 2'b11;
        @(posedge clk);
        #1;
        flush = 1'b0;
        in_valid = 2'b00;
        chk("fl_en0", 32'(eu0_en_out), 32'd0);
        chk("fl_en1", 32'(eu1_en_out), 32'd0);
        chk("fl_ready", 32'(in_ready), 32'd1);
        stall = 1'b0;
        @(posedge clk);
        #1;
        chk("fl_push_ignored", 32'(eu0_en_out), 32'd0);

        // queue works normally after flush
        exp_push(1'b1, 5'd1, 5'd2, 32'h800);
        push2(mk(U_ALU, 5'd1, 5'd0, 5'd0, 32'h800, 7'h0, 1'b0),
              mk(U_ALU, 5'd2, 5'd0, 5'd0, 32'h804, 7'h0, 1'b0));
        drain();

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule
